// File: rtl/core_lsu_mmio.sv
`default_nettype none
// ============================================================================
// Module      : core_lsu_mmio
// Description : Load/store unit that routes core requests to memory, to
//               memory-mapped stdin channels, or to buffered stdout channels.
// Revision    : 1.0 - initial release
// ============================================================================
module core_lsu_mmio #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int NCH        = 1,
    parameter int MEM_LAT    = 1,
    parameter int OBUF_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_val_i,
    output logic              req_rdy_o,
    input  logic              req_wen_i,
    input  logic [AW-1:0]     req_addr_i,
    input  logic [DW-1:0]     req_data_i,
    output logic              rsp_val_o,
    input  logic              rsp_rdy_i,
    output logic [DW-1:0]     rsp_data_o,
    input  logic [NCH-1:0]    in_val_i,
    output logic [NCH-1:0]    in_rdy_o,
    input  logic [NCH*DW-1:0] in_data_i,
    output logic [NCH-1:0]    out_val_o,
    input  logic [NCH-1:0]    out_rdy_i,
    output logic [NCH*DW-1:0] out_data_o,
    output logic              mem_val_o,
    output logic              mem_wen_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic [DW-1:0]     mem_rdata_i
);

    localparam int c_PW = $clog2(OBUF_DEPTH);
    localparam int c_LW = 3;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_RSP_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic [c_LW-1:0] r_lat_cnt;
    logic [DW-1:0]   r_rsp_data;

    logic [NCH-1:0]  w_hit;
    logic [NCH-1:0]  w_full;
    logic [NCH-1:0]  w_push;
    logic            w_idle;
    logic            w_is_io;
    logic            w_sel_in_val;
    logic            w_sel_full;
    logic [DW-1:0]   w_sel_in_data;
    logic            w_req_rdy;
    logic            w_accept;
    logic            w_mem_req;

    // Channel c sits at the top of the address space, counting downwards.
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_decode
            localparam logic [AW-1:0] c_CH_ADDR = {AW{1'b1}} - AW'(c);
            assign w_hit[c] = (req_addr_i == c_CH_ADDR);
        end
    endgenerate

    assign w_idle  = (r_state == c_IDLE);
    assign w_is_io = |w_hit;

    always_comb begin
        w_sel_in_val  = 1'b0;
        w_sel_full    = 1'b0;
        w_sel_in_data = '0;
        for (int c = 0; c < NCH; c++) begin
            if (w_hit[c]) begin
                w_sel_in_val  = in_val_i[c];
                w_sel_full    = w_full[c];
                w_sel_in_data = in_data_i[c*DW +: DW];
            end
        end
    end

    always_comb begin
        w_req_rdy = 1'b0;
        if (w_idle) begin
            if (!w_is_io) begin
                w_req_rdy = 1'b1;
            end else if (req_wen_i) begin
                w_req_rdy = !w_sel_full;
            end else begin
                w_req_rdy = w_sel_in_val;
            end
        end
    end

    assign req_rdy_o   = w_req_rdy;
    assign w_accept    = req_val_i & w_req_rdy;
    assign w_mem_req   = w_idle & req_val_i & !w_is_io;
    assign mem_val_o   = w_mem_req;
    assign mem_wen_o   = w_mem_req & req_wen_i;
    assign mem_addr_o  = w_mem_req ? req_addr_i : '0;
    assign mem_wdata_o = (w_mem_req & req_wen_i) ? req_data_i : '0;
    assign in_rdy_o    = (w_idle & req_val_i & !req_wen_i) ? w_hit : '0;
    assign w_push      = (w_accept & req_wen_i) ? w_hit : '0;
    assign rsp_val_o   = (r_state == c_RSP_HOLD);
    assign rsp_data_o  = r_rsp_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_IDLE;
            r_lat_cnt  <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept && !req_wen_i) begin
                        if (w_is_io) begin
                            r_rsp_data <= w_sel_in_data;
                            r_state    <= c_RSP_HOLD;
                        end else begin
                            r_lat_cnt <= c_LW'(MEM_LAT - 1);
                            r_state   <= c_MEM_WAIT;
                        end
                    end
                end
                c_MEM_WAIT: begin
                    // Counter reaching zero marks the cycle the read data is valid.
                    if (r_lat_cnt == '0) begin
                        r_rsp_data <= mem_rdata_i;
                        r_state    <= c_RSP_HOLD;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                c_RSP_HOLD: begin
                    if (rsp_rdy_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_obuf
            logic [DW-1:0]   r_buf [OBUF_DEPTH];
            logic [c_PW-1:0] r_wptr;
            logic [c_PW-1:0] r_rptr;
            logic [c_PW:0]   r_count;
            logic            w_pop;

            assign w_full[c]              = (r_count == (c_PW+1)'(OBUF_DEPTH));
            assign out_val_o[c]           = (r_count != '0);
            assign out_data_o[c*DW +: DW] = r_buf[r_rptr];
            assign w_pop                  = (r_count != '0) & out_rdy_i[c];

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[c]) begin
                        r_buf[r_wptr] <= req_data_i;
                        r_wptr        <= r_wptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    case ({w_push[c], w_pop})
                        2'b10:   r_count <= r_count + 1'b1;
                        2'b01:   r_count <= r_count - 1'b1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_core_lsu_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_lsu_mmio
// Description : Directed self-checking bench for core_lsu_mmio (NCH=2, MEM_LAT=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_lsu_mmio;

    localparam int c_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_val = 1'b0, req_wen = 1'b0;
    logic        req_rdy;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_data = '0;
    logic        rsp_val;
    logic        rsp_rdy = 1'b0;
    logic [15:0] rsp_data;
    logic [1:0]  in_val = '0, in_rdy;
    logic [31:0] in_data = '0;
    logic [1:0]  out_val, out_rdy = '0;
    logic [31:0] out_data;
    logic        mem_val, mem_wen;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    core_lsu_mmio #(.AW(8), .DW(16), .NCH(2), .MEM_LAT(c_LAT), .OBUF_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_val_i(req_val), .req_rdy_o(req_rdy), .req_wen_i(req_wen),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .rsp_val_o(rsp_val), .rsp_rdy_i(rsp_rdy), .rsp_data_o(rsp_data),
        .in_val_i(in_val), .in_rdy_o(in_rdy), .in_data_i(in_data),
        .out_val_o(out_val), .out_rdy_i(out_rdy), .out_data_o(out_data),
        .mem_val_o(mem_val), .mem_wen_o(mem_wen), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data is valid only in the cycle MEM_LAT after the request.
    logic [15:0] bmem [256];
    logic [7:0]  pend_addr = '0;
    int          lat = -1;
    always @(posedge clk) begin
        if (mem_val && mem_wen) bmem[mem_addr] <= mem_wdata;
        if (mem_val && !mem_wen) begin
            pend_addr <= mem_addr;
            lat       <= c_LAT - 1;
        end else if (lat >= 0) begin
            lat <= lat - 1;
        end
    end
    assign mem_rdata = (lat == 0) ? bmem[pend_addr] : 16'hDEAD;

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic mem_store(input logic [7:0] a, input logic [15:0] d);
        cyc();
        req_val = 1'b1; req_wen = 1'b1; req_addr = a; req_data = d;
        @(negedge clk);
        checks++; if ({req_rdy, mem_val, mem_wen, mem_addr, mem_wdata} !== {3'b111, a, d}) begin
            errors++; $display("FAIL store_%h: got rdy/val/wen=%b%b%b addr=%h wdata=%h exp 111 %h %h", a, req_rdy, mem_val, mem_wen, mem_addr, mem_wdata, a, d); end
        cyc();
        req_val = 1'b0; req_wen = 1'b0;
    endtask

    task automatic mem_load_check(input logic [7:0] a, input logic [15:0] exp);
        cyc();
        req_val = 1'b1; req_wen = 1'b0; req_addr = a; req_data = '0;
        @(negedge clk);
        checks++; if ({req_rdy, mem_val, mem_wen, mem_addr, mem_wdata} !== {3'b110, a, 16'h0}) begin
            errors++; $display("FAIL load_issue_%h: got rdy/val/wen=%b%b%b addr=%h wdata=%h exp 110 %h 0000", a, req_rdy, mem_val, mem_wen, mem_addr, mem_wdata, a); end
        cyc(); req_val = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_val, req_rdy} !== 2'b00) begin
            errors++; $display("FAIL load_wait1_%h: got rsp_val/req_rdy=%b%b exp 00", a, rsp_val, req_rdy); end
        cyc(); @(negedge clk);
        checks++; if (rsp_val !== 1'b0) begin
            errors++; $display("FAIL load_wait2_%h: got rsp_val=%b exp 0", a, rsp_val); end
        cyc(); @(negedge clk);
        checks++; if ({rsp_val, rsp_data} !== {1'b1, exp}) begin
            errors++; $display("FAIL load_rsp_%h: got val=%b data=%h exp 1 %h", a, rsp_val, rsp_data, exp); end
        rsp_rdy = 1'b1; cyc(); rsp_rdy = 1'b0;
        @(negedge clk);
        checks++; if (rsp_val !== 1'b0) begin
            errors++; $display("FAIL load_done_%h: got rsp_val=%b exp 0", a, rsp_val); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        checks++; if ({rsp_val, out_val, in_rdy, mem_val, rsp_data} !== {6'b0, 16'h0}) begin
            errors++; $display("FAIL reset_state: got rsp_val=%b out_val=%b in_rdy=%b mem_val=%b rsp_data=%h exp all 0", rsp_val, out_val, in_rdy, mem_val, rsp_data); end
        cyc(); rst = 1'b0;
    endtask

    task automatic test_mem();
        mem_store(8'h10, 16'hBEEF);
        mem_store(8'h11, 16'h1357);
        mem_load_check(8'h10, 16'hBEEF);
        mem_load_check(8'h11, 16'h1357);
    endtask

    task automatic test_stdout_fifo();
        cyc();
        out_rdy = 2'b00; req_val = 1'b1; req_wen = 1'b1; req_addr = 8'hFF; req_data = 16'h0001;
        @(negedge clk);
        checks++; if ({req_rdy, mem_val, in_rdy} !== 4'b1000) begin
            errors++; $display("FAIL fifo_push1: got rdy=%b mem_val=%b in_rdy=%b exp 1 0 00", req_rdy, mem_val, in_rdy); end
        cyc(); req_data = 16'h0002;
        @(negedge clk);
        checks++; if ({req_rdy, out_val[0], out_data[15:0]} !== {2'b11, 16'h0001}) begin
            errors++; $display("FAIL fifo_push2: got rdy=%b oval=%b head=%h exp 1 1 0001", req_rdy, out_val[0], out_data[15:0]); end
        cyc(); req_data = 16'h0003;
        @(negedge clk);
        checks++; if (req_rdy !== 1'b0) begin
            errors++; $display("FAIL fifo_full: got rdy=%b exp 0", req_rdy); end
        cyc(); out_rdy = 2'b01;
        @(negedge clk);
        checks++; if ({req_rdy, out_data[15:0]} !== {1'b0, 16'h0001}) begin
            errors++; $display("FAIL fifo_pop1: got rdy=%b head=%h exp 0 0001", req_rdy, out_data[15:0]); end
        cyc();
        @(negedge clk);
        checks++; if ({req_rdy, out_data[15:0]} !== {1'b1, 16'h0002}) begin
            errors++; $display("FAIL fifo_pop2: got rdy=%b head=%h exp 1 0002", req_rdy, out_data[15:0]); end
        cyc(); req_val = 1'b0;
        @(negedge clk);
        checks++; if ({out_val[0], out_data[15:0]} !== {1'b1, 16'h0003}) begin
            errors++; $display("FAIL fifo_pop3: got oval=%b head=%h exp 1 0003", out_val[0], out_data[15:0]); end
        cyc();
        @(negedge clk);
        checks++; if (out_val !== 2'b00) begin
            errors++; $display("FAIL fifo_empty: got out_val=%b exp 00", out_val); end
        out_rdy = 2'b00; req_wen = 1'b0;
    endtask

    task automatic test_push_pop();
        cyc();
        req_val = 1'b1; req_wen = 1'b1; req_addr = 8'hFE; req_data = 16'hAAAA; out_rdy = 2'b00;
        cyc(); req_data = 16'hBBBB; out_rdy = 2'b10;
        @(negedge clk);
        checks++; if ({req_rdy, out_val, out_data[31:16]} !== {3'b110, 16'hAAAA}) begin
            errors++; $display("FAIL pushpop_before: got rdy=%b oval=%b head=%h exp 1 10 aaaa", req_rdy, out_val, out_data[31:16]); end
        cyc(); req_val = 1'b0;
        @(negedge clk);
        checks++; if ({out_val, out_data[31:16]} !== {2'b10, 16'hBBBB}) begin
            errors++; $display("FAIL pushpop_after: got oval=%b head=%h exp 10 bbbb", out_val, out_data[31:16]); end
        cyc();
        @(negedge clk);
        checks++; if (out_val !== 2'b00) begin
            errors++; $display("FAIL pushpop_count: got out_val=%b exp 00", out_val); end
        out_rdy = 2'b00; req_wen = 1'b0;
    endtask

    task automatic test_stdin();
        cyc();
        req_val = 1'b1; req_wen = 1'b0; req_addr = 8'hFE; in_val = 2'b00; in_data = {16'h1234, 16'h5555};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if ({req_rdy, in_rdy, mem_val} !== 4'b0100) begin
                errors++; $display("FAIL stdin_stall%0d: got rdy=%b in_rdy=%b mem_val=%b exp 0 10 0", i, req_rdy, in_rdy, mem_val); end
            cyc();
        end
        in_val = 2'b10;
        @(negedge clk);
        checks++; if ({req_rdy, in_rdy} !== 3'b110) begin
            errors++; $display("FAIL stdin_go: got rdy=%b in_rdy=%b exp 1 10", req_rdy, in_rdy); end
        cyc(); req_val = 1'b0; in_val = 2'b00;
        @(negedge clk);
        checks++; if ({rsp_val, rsp_data} !== {1'b1, 16'h1234}) begin
            errors++; $display("FAIL stdin_rsp: got val=%b data=%h exp 1 1234", rsp_val, rsp_data); end
        rsp_rdy = 1'b1; cyc(); rsp_rdy = 1'b0;
    endtask

    task automatic test_rsp_hold();
        cyc();
        req_val = 1'b1; req_wen = 1'b0; req_addr = 8'hFF; in_val = 2'b01; in_data = {16'h0, 16'hA5A5}; rsp_rdy = 1'b0;
        @(negedge clk);
        checks++; if ({req_rdy, in_rdy} !== 3'b101) begin
            errors++; $display("FAIL hold_accept: got rdy=%b in_rdy=%b exp 1 01", req_rdy, in_rdy); end
        cyc(); in_val = 2'b00; req_wen = 1'b1; req_addr = 8'h20; req_data = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({rsp_val, req_rdy, mem_val, rsp_data} !== {3'b100, 16'hA5A5}) begin
                errors++; $display("FAIL hold_stable%0d: got val/rdy/mval=%b%b%b data=%h exp 100 a5a5", i, rsp_val, req_rdy, mem_val, rsp_data); end
            cyc();
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        checks++; if ({rsp_val, req_rdy, mem_val} !== 3'b100) begin
            errors++; $display("FAIL hold_release: got val/rdy/mval=%b%b%b exp 100", rsp_val, req_rdy, mem_val); end
        cyc(); rsp_rdy = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_val, req_rdy, mem_val, mem_addr} !== {3'b011, 8'h20}) begin
            errors++; $display("FAIL hold_store: got val/rdy/mval=%b%b%b addr=%h exp 011 20", rsp_val, req_rdy, mem_val, mem_addr); end
        cyc(); req_val = 1'b0; req_wen = 1'b0;
        mem_load_check(8'h20, 16'h7777);
    endtask

    task automatic test_back_to_back();
        cyc();
        req_val = 1'b1; req_wen = 1'b1; req_addr = 8'h40; req_data = 16'h0A0A;
        @(negedge clk);
        checks++; if ({req_rdy, mem_val} !== 2'b11) begin
            errors++; $display("FAIL b2b_st1: got rdy=%b mval=%b exp 11", req_rdy, mem_val); end
        cyc(); req_addr = 8'hFE; req_data = 16'h0B0B;
        @(negedge clk);
        checks++; if ({req_rdy, mem_val} !== 2'b10) begin
            errors++; $display("FAIL b2b_st2: got rdy=%b mval=%b exp 10", req_rdy, mem_val); end
        cyc(); req_addr = 8'h41; req_data = 16'h0C0C;
        @(negedge clk);
        checks++; if ({req_rdy, mem_val, mem_wdata} !== {2'b11, 16'h0C0C}) begin
            errors++; $display("FAIL b2b_st3: got rdy=%b mval=%b wdata=%h exp 11 0c0c", req_rdy, mem_val, mem_wdata); end
        cyc(); req_val = 1'b0; req_wen = 1'b0;
        @(negedge clk);
        checks++; if ({out_val, out_data[31:16]} !== {2'b10, 16'h0B0B}) begin
            errors++; $display("FAIL b2b_out: got oval=%b head=%h exp 10 0b0b", out_val, out_data[31:16]); end
        mem_load_check(8'h41, 16'h0C0C);
        mem_load_check(8'h40, 16'h0A0A);
    endtask

    task automatic test_reset_mem_wait();
        cyc();
        req_val = 1'b1; req_wen = 1'b1; req_addr = 8'hFF; req_data = 16'hCAFE;
        cyc(); req_wen = 1'b0; req_addr = 8'h10;
        @(negedge clk);
        checks++; if ({out_val[0], mem_val, req_rdy} !== 3'b111) begin
            errors++; $display("FAIL rstw_setup: got oval0=%b mval=%b rdy=%b exp 111", out_val[0], mem_val, req_rdy); end
        cyc(); req_val = 1'b0; rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_val, out_val, req_rdy, rsp_data} !== {4'b0001, 16'h0}) begin
            errors++; $display("FAIL rstw_idle: got val=%b oval=%b rdy=%b data=%h exp 0 00 1 0000", rsp_val, out_val, req_rdy, rsp_data); end
        for (int i = 0; i < 3; i++) begin
            cyc(); @(negedge clk);
            checks++; if (rsp_val !== 1'b0) begin
                errors++; $display("FAIL rstw_norsp%0d: got rsp_val=%b exp 0", i, rsp_val); end
        end
        mem_store(8'h30, 16'h1111);
        mem_load_check(8'h30, 16'h1111);
    endtask

    initial begin
        test_reset();
        test_mem();
        test_stdout_fifo();
        test_push_pop();
        test_stdin();
        test_rsp_hold();
        test_back_to_back();
        test_reset_mem_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/core_lsu_mmio.md
CORE_LSU_MMIO -- requirements
Module: core_lsu_mmio

Interface
REQ-001 SHALL have parameters (name, default, meaning): AW, 8, address width; DW, 16, data width; NCH, 1, number of stdio channels (1..8); MEM_LAT, 1, memory read latency in cycles (1..4); OBUF_DEPTH, 2, per-channel output FIFO depth (power of 2, >=2).
REQ-002 SHALL have ports (name direction width meaning): clk_i in 1 clock; rst_i in 1 reset.
REQ-003 Reset SHALL be synchronous and active-high on rst_i; the block SHALL have a single clock, clk_i.
REQ-004 Request ports: req_val_i in 1 request valid; req_rdy_o out 1 request accepted; req_wen_i in 1 store(1)/load(0); req_addr_i in AW address; req_data_i in DW store data.
REQ-005 Response ports: rsp_val_o out 1 load data valid; rsp_rdy_i in 1 core accepts load data; rsp_data_o out DW load data.
REQ-006 Stdin ports: in_val_i in NCH; in_rdy_o out NCH; in_data_i in NCH*DW, channel c at bits [c*DW +: DW].
REQ-007 Stdout ports: out_val_o out NCH; out_rdy_i in NCH; out_data_o out NCH*DW, same packing.
REQ-008 Memory ports: mem_val_o out 1; mem_wen_o out 1; mem_addr_o out AW; mem_wdata_o out DW; mem_rdata_i in DW. Memory is always ready.

Function
REQ-009 Address map SHALL be: channel c at address 2^AW-1-c for c in 0..NCH-1; all other addresses are memory.
REQ-010 A request SHALL transfer when req_val_i and req_rdy_o are both high on a rising edge; req_rdy_o SHALL be low outside IDLE.
REQ-011 The FSM SHALL have states IDLE, MEM_WAIT and RSP_HOLD.
REQ-012 Memory store in IDLE: req_rdy_o=1; mem_val_o=1, mem_wen_o=1, mem_addr_o/mem_wdata_o driven from the request, all in the same cycle; FSM stays IDLE; no response.
REQ-013 Memory load in IDLE: req_rdy_o=1; mem_val_o=1, mem_wen_o=0; go to MEM_WAIT with the latency counter loaded to MEM_LAT-1.
REQ-014 Latency timing: for a load accepted in cycle T, mem_rdata_i SHALL be sampled at the end of cycle T+MEM_LAT into the response register; the FSM then enters RSP_HOLD, so rsp_val_o is first high in cycle T+MEM_LAT+1.
REQ-015 Stdin load to channel c in IDLE: in_rdy_o[c]=1 and req_rdy_o=in_val_i[c], both combinational; on transfer, in_data_i[c] is captured into the response register and the FSM goes to RSP_HOLD. Both handshakes complete in the same cycle; a pending stdin load stalls with no timeout.
REQ-016 Stdout store to channel c in IDLE: req_rdy_o=!full[c]; on transfer, req_data_i is pushed into FIFO c; no response. The full state is taken at the start of the cycle (no bypass).
REQ-017 Output FIFO c: out_val_o[c]=!empty[c]; out_data_o[c]=head. A pop occurs on out_val_o[c]&out_rdy_i[c]. A simultaneous push and pop SHALL keep the count unchanged and preserve FIFO order. Pointers wrap modulo OBUF_DEPTH.
REQ-018 RSP_HOLD: rsp_val_o=1 and rsp_data_o stable until rsp_rdy_i=1. On that edge the FSM goes to IDLE; no new request is accepted in the same cycle.
REQ-019 Outside RSP_HOLD, rsp_val_o SHALL be 0. rsp_data_o SHALL hold its last value.
REQ-020 Inputs to unused mem_* outputs SHALL be driven 0 whenever mem_val_o=0; in_rdy_o SHALL be 0 except as in REQ-015.
REQ-021 Only one load SHALL be outstanding at a time; stores are never blocked by memory latency, only by state and FIFO full.

Reset
REQ-022 While rst_i=1 at a rising edge: FSM=IDLE, latency counter=0, response register=0, all FIFOs empty (out_val_o=0), rsp_val_o=0.
REQ-023 Reset during MEM_WAIT or RSP_HOLD SHALL discard the load; a late mem_rdata_i SHALL be ignored and no rsp_val_o pulse SHALL follow.
REQ-024 Reset SHALL drop all buffered stdout words.

Verification
REQ-025 MEM_LAT=2: store 0xBEEF to 0x10, then load 0x10 accepted in cycle T -> mem_val_o=1 in T, rsp_val_o first high in T+3, rsp_data_o=0xBEEF.
REQ-026 NCH=1, OBUF_DEPTH=2, out_rdy_i=0: store 0x0001, 0x0002, 0x0003 to 0xFF -> first two accepted, third sees req_rdy_o=0; after raising out_rdy_i, output is 0x0001 then 0x0002, the third is accepted the cycle after the first pop, and 0x0003 follows.
REQ-027 NCH=2: load 0xFE with in_val_i[1]=0 for 5 cycles -> req_rdy_o=0 and in_rdy_o=2'b10 throughout; in_val_i[1]=1 with data 0x1234 -> rsp_data_o=0x1234 the next cycle.
REQ-028 Load response with rsp_rdy_i=0 for 3 cycles plus a queued store -> rsp_val_o and data stable for 3 cycles, store not accepted until the cycle after rsp_rdy_i=1.
REQ-029 rst_i=1 in MEM_WAIT (MEM_LAT=3) -> IDLE next cycle, rsp_val_o never asserts, the next request is accepted normally.
REQ-030 Simultaneous push and pop on a FIFO holding 1 word -> count stays at 1, order preserved.
